change_dispenser: RTL and testbench
===================================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, 15, maximum cycles spent in WAIT_ACK before a fault.
REQ-002 SHALL have parameter DOLLAR_Q, 4, quarters per dollar coin.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port i_clk  input  1  clock, rising edge.
REQ-005 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port i_req  input  1  one-cycle payout request; i_change is valid in the same cycle.
REQ-007 SHALL have port i_change  input  5  change owed, in quarters (0-31).
REQ-008 SHALL have port i_hopper_ack  input  1  hopper confirms one coin dropped.
REQ-009 SHALL have port i_dollar_empty  input  1  dollar tube empty.
REQ-010 SHALL have port i_quarter_empty  input  1  quarter tube empty.
REQ-011 SHALL have port i_clear  input  1  clears the FAULT state.
REQ-012 SHALL have port o_dollar_eject  output  1  one-cycle dollar eject pulse.
REQ-013 SHALL have port o_quarter_eject  output  1  one-cycle quarter eject pulse.
REQ-014 SHALL have port o_busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port o_done  output  1  one-cycle pulse when payout is complete.
REQ-016 SHALL have port o_fault  output  1  high while in FAULT.
REQ-017 SHALL have port o_remaining  output  5  quarters still owed.

Function
REQ-018 SHALL implement the states IDLE, SELECT, EJECT, WAIT_ACK, DONE and FAULT; all outputs SHALL be registered.
REQ-019 IDLE: on i_req, SHALL latch i_change into remaining and go to SELECT; i_req in any other state SHALL be ignored.
REQ-020 SELECT, priority order: remaining==0 -> DONE; remaining>=DOLLAR_Q and !i_dollar_empty -> EJECT(dollar); remaining>=1 and !i_quarter_empty -> EJECT(quarter); otherwise -> FAULT.
REQ-021 EJECT SHALL assert the selected eject output for exactly one cycle, load the timer with 0, and go to WAIT_ACK; the two eject outputs SHALL never be high together.
REQ-022 WAIT_ACK: on i_hopper_ack, SHALL subtract the coin value (DOLLAR_Q or 1) from remaining and return to SELECT.
REQ-023 WAIT_ACK: if the timer reaches ACK_TIMEOUT without an ack, SHALL go to FAULT with remaining unchanged.
REQ-024 An i_hopper_ack outside WAIT_ACK SHALL be ignored; remaining SHALL never underflow.
REQ-025 DONE SHALL pulse o_done for one cycle and return to IDLE.
REQ-026 FAULT SHALL hold o_fault=1 and o_remaining constant until i_clear, then go to IDLE with remaining=0.
REQ-027 Latency: for an i_req sampled at edge N with nonzero change, the first eject pulse SHALL be high in the cycle after edge N+2.
REQ-028 For i_req with i_change=0, o_done SHALL pulse in the cycle after edge N+2 with no eject pulse.
REQ-029 A tube-empty signal SHALL be sampled only in SELECT; if the dollar tube is empty, the payout SHALL fall back to quarters.
REQ-030 o_remaining SHALL always equal the latched remaining value.

Reset
REQ-031 While i_rst_n=0, state SHALL be IDLE and remaining, the timer and all outputs SHALL be 0, regardless of i_clk.
REQ-032 Reset asserted mid-payout SHALL abort the payout with no further eject pulses; deassertion SHALL be followed by IDLE.

Verification
REQ-033 i_change=6, tubes full, ack 2 cycles after each eject -> eject order dollar, quarter, quarter; o_remaining 6->2->1->0; one o_done pulse.
REQ-034 i_change=0 -> o_done pulses once with no eject; o_busy is high for 2 cycles.
REQ-035 i_change=5, i_dollar_empty=1 -> exactly 5 quarter pulses, no dollar pulse, then o_done.
REQ-036 i_change=4, no ack -> one dollar pulse; o_fault rises after ACK_TIMEOUT cycles with o_remaining=4; after i_clear, the block is in IDLE with o_busy=0.
REQ-037 i_change=3, i_quarter_empty=1 -> no eject; FAULT with o_remaining=3.
REQ-038 i_change=8, i_rst_n pulsed low after the first ack -> all outputs 0 immediately; no further ejects; a new i_req=2 pays 2 quarters.

Source files
------------

// File: rtl/change_dispenser.sv
// change_dispenser: pays out owed change as dollar coins first, then quarters.
// Each coin is ejected with a one-cycle pulse and must be confirmed by the
// hopper before the next coin is selected. A missing confirmation or an empty
// tube parks the block in FAULT until it is explicitly cleared.
//
// Handshakes: i_req is a one-cycle strobe that is honoured only in IDLE, with
// i_change valid in the same cycle. i_hopper_ack is honoured only while a
// coin is waiting for confirmation. Every output is a register.
module change_dispenser #(
    parameter int ACK_TIMEOUT = 15,
    parameter int DOLLAR_Q    = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_req,
    input  logic [4:0] i_change,
    input  logic       i_hopper_ack,
    input  logic       i_dollar_empty,
    input  logic       i_quarter_empty,
    input  logic       i_clear,
    output logic       o_dollar_eject,
    output logic       o_quarter_eject,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_fault,
    output logic [4:0] o_remaining,
    output logic [2:0] o_state
);

    // The timer counts 0 .. ACK_TIMEOUT-1, one value per cycle spent waiting.
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SELECT   = 3'd1,
        EJECT    = 3'd2,
        WAIT_ACK = 3'd3,
        DONE     = 3'd4,
        FAULT    = 3'd5
    } state_t;

    state_t        state, state_next;
    logic [4:0]    remaining, remaining_next;
    logic [TW-1:0] timer, timer_next;
    logic          sel_dollar, sel_dollar_next;
    logic          dollar_next, quarter_next, done_next, busy_next, fault_next;
    logic [4:0]    coin;

    assign o_remaining = remaining;
    assign o_state     = state;

    // State, payout bookkeeping and all registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= IDLE;
            remaining       <= 5'd0;
            timer           <= '0;
            sel_dollar      <= 1'b0;
            o_dollar_eject  <= 1'b0;
            o_quarter_eject <= 1'b0;
            o_busy          <= 1'b0;
            o_done          <= 1'b0;
            o_fault         <= 1'b0;
        end else begin
            state           <= state_next;
            remaining       <= remaining_next;
            timer           <= timer_next;
            sel_dollar      <= sel_dollar_next;
            o_dollar_eject  <= dollar_next;
            o_quarter_eject <= quarter_next;
            o_busy          <= busy_next;
            o_done          <= done_next;
            o_fault         <= fault_next;
        end
    end

    // Next-state logic; output registers are loaded from the upcoming state so
    // the pulses appear in the cycle after the state that requests them.
    always_comb begin
        state_next      = state;
        remaining_next  = remaining;
        timer_next      = timer;
        sel_dollar_next = sel_dollar;
        dollar_next     = 1'b0;
        quarter_next    = 1'b0;
        done_next       = 1'b0;
        coin            = sel_dollar ? 5'(DOLLAR_Q) : 5'd1;

        case (state)
            IDLE: begin
                if (i_req) begin
                    remaining_next = i_change;
                    state_next     = SELECT;
                end
            end
            SELECT: begin
                // Tube-empty flags matter only here; an empty dollar tube
                // simply falls through to quarters.
                if (remaining == 5'd0) begin
                    state_next = DONE;
                end else if (remaining >= 5'(DOLLAR_Q) && !i_dollar_empty) begin
                    sel_dollar_next = 1'b1;
                    state_next      = EJECT;
                end else if (!i_quarter_empty) begin
                    sel_dollar_next = 1'b0;
                    state_next      = EJECT;
                end else begin
                    state_next = FAULT;
                end
            end
            EJECT: begin
                dollar_next  = sel_dollar;
                quarter_next = !sel_dollar;
                timer_next   = '0;
                state_next   = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (i_hopper_ack) begin
                    // Guard keeps remaining from wrapping even if selection
                    // were ever bypassed.
                    if (remaining >= coin) begin
                        remaining_next = remaining - coin;
                    end
                    state_next = SELECT;
                end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
                    state_next = FAULT;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            DONE: begin
                done_next  = 1'b1;
                state_next = IDLE;
            end
            FAULT: begin
                if (i_clear) begin
                    remaining_next = 5'd0;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next  = (state_next != IDLE);
        fault_next = (state_next == FAULT);
    end

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: scoreboard bench. Each payout pushes the expected
// coin/done events (kind plus o_remaining at that moment) into exp_q; a
// monitor pops and compares them as the pulses appear.
module tb_change_dispenser;

  localparam int ACK_TIMEOUT = 15;
  localparam int DOLLAR_Q    = 4;

  localparam logic [1:0] K_DOLLAR  = 2'd1;
  localparam logic [1:0] K_QUARTER = 2'd2;
  localparam logic [1:0] K_DONE    = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic [4:0] change = 5'd0;
  logic       hopper_ack = 1'b0;
  logic       dollar_empty = 1'b0;
  logic       quarter_empty = 1'b0;
  logic       clear = 1'b0;
  logic       dollar_eject, quarter_eject, busy, done, fault;
  logic [4:0] remaining;
  logic [2:0] state_dbg;

  logic       ack_en = 1'b1;
  int         ack_delay = 1;

  logic [6:0] exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  change_dispenser #(.ACK_TIMEOUT(ACK_TIMEOUT), .DOLLAR_Q(DOLLAR_Q)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_req(req),
    .i_change(change),
    .i_hopper_ack(hopper_ack),
    .i_dollar_empty(dollar_empty),
    .i_quarter_empty(quarter_empty),
    .i_clear(clear),
    .o_dollar_eject(dollar_eject),
    .o_quarter_eject(quarter_eject),
    .o_busy(busy),
    .o_done(done),
    .o_fault(fault),
    .o_remaining(remaining),
    .o_state(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference payout: dollars while allowed, then quarters, then done.
  task automatic push_payout(input int c, input logic no_dollars);
    int rem = c;
    while (rem >= DOLLAR_Q && !no_dollars) begin
      exp_q.push_back({K_DOLLAR, 5'(rem)});
      rem -= DOLLAR_Q;
    end
    while (rem > 0) begin
      exp_q.push_back({K_QUARTER, 5'(rem)});
      rem -= 1;
    end
    exp_q.push_back({K_DONE, 5'd0});
  endtask

  // Hopper model: confirm each eject ack_delay negedges later.
  initial begin
    forever begin
      @(negedge clk);
      if (ack_en && rst_n && (dollar_eject || quarter_eject)) begin
        repeat (ack_delay) @(negedge clk);
        hopper_ack = 1'b1;
        @(negedge clk);
        hopper_ack = 1'b0;
      end
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n && (dollar_eject || quarter_eject || done)) begin
      logic [6:0] got;
      got = {dollar_eject ? K_DOLLAR : (quarter_eject ? K_QUARTER : K_DONE), remaining};
      check("eject_onehot", {31'd0, dollar_eject & quarter_eject}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_event", {25'd0, got}, 32'h7f);
      end else begin
        check("event", {25'd0, got}, {25'd0, exp_q.pop_front()});
      end
    end
  end

  // driver tasks
  task automatic do_req(input logic [4:0] c);
    @(negedge clk);
    req = 1'b1;
    change = c;
    @(negedge clk);
    req = 1'b0;
    change = $urandom_range(0, 31);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!done) check({tag, "_done_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    check({tag, "_q_empty"}, exp_q.size(), 32'd0);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_fault(input string tag, output int n);
    n = 0;
    while (!fault && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!fault) check({tag, "_fault_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    int n;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_outs", {27'd0, dollar_eject, quarter_eject, done, fault, 1'b0}, 32'd0);
    check("rst_remaining", {27'd0, remaining}, 32'd0);
    check("rst_state", {29'd0, state_dbg}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // change 6: dollar, quarter, quarter; first eject two cycles after req edge.
    push_payout(6, 1'b0);
    do_req(5'd6);
    check("sel_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("latency_early", {31'd0, dollar_eject}, 32'd0);
    @(negedge clk);
    check("latency_eject", {31'd0, dollar_eject}, 32'd1);
    wait_done("c6");

    // change 0: done only, busy for two cycles.
    push_payout(0, 1'b0);
    do_req(5'd0);
    check("z_busy1", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("z_busy2", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("z_done", {31'd0, done}, 32'd1);
    check("z_busy_end", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("z_q_empty", exp_q.size(), 32'd0);

    // change 5 with an empty dollar tube: five quarters.
    dollar_empty = 1'b1;
    push_payout(5, 1'b1);
    do_req(5'd5);
    wait_done("c5");
    dollar_empty = 1'b0;

    // change 4, hopper silent: one dollar then timeout fault.
    ack_en = 1'b0;
    exp_q.push_back({K_DOLLAR, 5'd4});
    do_req(5'd4);
    @(negedge clk);
    @(negedge clk);
    check("to_eject", {31'd0, dollar_eject}, 32'd1);
    wait_fault("to", n);
    check("to_cycles", n, ACK_TIMEOUT);
    check("to_remaining", {27'd0, remaining}, 32'd4);
    // Ack and a new request are both ignored in FAULT.
    hopper_ack = 1'b1;
    req = 1'b1;
    change = 5'd9;
    repeat (3) @(negedge clk);
    hopper_ack = 1'b0;
    req = 1'b0;
    check("to_hold_fault", {31'd0, fault}, 32'd1);
    check("to_hold_rem", {27'd0, remaining}, 32'd4);
    do_clear();
    check("clr_busy", {31'd0, busy}, 32'd0);
    check("clr_fault", {31'd0, fault}, 32'd0);
    check("clr_rem", {27'd0, remaining}, 32'd0);
    check("clr_state", {29'd0, state_dbg}, 32'd0);
    check("to_q_empty", exp_q.size(), 32'd0);
    ack_en = 1'b1;

    // change 3, quarter tube empty: straight to fault.
    quarter_empty = 1'b1;
    do_req(5'd3);
    wait_fault("qe", n);
    check("qe_remaining", {27'd0, remaining}, 32'd3);
    quarter_empty = 1'b0;
    do_clear();
    check("qe_idle", {31'd0, busy}, 32'd0);

    // change 8, reset after the first ack.
    exp_q.push_back({K_DOLLAR, 5'd8});
    do_req(5'd8);
    n = 0;
    while (remaining != 5'd4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rs_first_ack", {27'd0, remaining}, 32'd4);
    rst_n = 1'b0;
    #1;
    check("rs_outs", {27'd0, dollar_eject, quarter_eject, done, fault, busy}, 32'd0);
    check("rs_remaining", {27'd0, remaining}, 32'd0);
    check("rs_q_empty", exp_q.size(), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("rs_state", {29'd0, state_dbg}, 32'd0);
    push_payout(2, 1'b0);
    do_req(5'd2);
    wait_done("rs2");

    // Random payouts with random hopper latency.
    for (int i = 0; i < 8; i++) begin
      int c;
      c = $urandom_range(0, 31);
      ack_delay = $urandom_range(0, 5);
      push_payout(c, 1'b0);
      do_req(5'(c));
      wait_done("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
